// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, funct
// codes, controller state encodings, ALU operation codes and aluop codes.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop: what the controller asks the ALU decoder for
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller states; codes 12-15 are illegal
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps aluop (and funct for R-type) to alucontrol.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // aluop 00/11 add, 01 subtract, 10 defers to funct (unknown funct adds)
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main controller: Moore FSM driving the datapath controls,
// plus the ALU decoder. The raw state register is exported on `state`.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_next;
  state_t     dec_state;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_d;
  logic       regwrite_d;
  logic       memwrite_d;

  assign state = state_q;

  // State register; synchronous reset returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_next;
  end

  // Next-state logic; illegal codes and unsupported opcodes go to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state_q)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // While reset is held the outputs show FETCH values regardless of the
  // (possibly mid-instruction) state register; write enables are masked below.
  assign dec_state = reset ? S_FETCH : state_q;

  // Moore output decode from the effective state
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    irwrite_d  = 1'b0;
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (dec_state)
      S_FETCH: begin
        irwrite_d = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_d = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are never asserted while reset is high
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign irwrite  = irwrite_d & ~reset;
  assign regwrite = regwrite_d & ~reset;
  assign memwrite = memwrite_d & ~reset;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-cycle vector table of
// {reset, op, funct, zero} -> {state, control word}, plus hand sequences.
module tb_multicycle_controller;

  // Control word layout:
  // {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
  //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
  localparam logic [14:0] C_FETCH   = 15'b1100_0000_01_00_010;
  localparam logic [14:0] C_RESET   = 15'b0000_0000_01_00_010;
  localparam logic [14:0] C_DECODE  = 15'b0000_0000_11_00_010;
  localparam logic [14:0] C_MEMADR  = 15'b0000_1000_10_00_010;
  localparam logic [14:0] C_MEMRD   = 15'b0000_0100_00_00_010;
  localparam logic [14:0] C_MEMWB   = 15'b0010_0010_00_00_010;
  localparam logic [14:0] C_MEMWR   = 15'b0001_0100_00_00_010;
  localparam logic [14:0] C_RTEX_AD = 15'b0000_1000_00_00_010;
  localparam logic [14:0] C_RTEX_SB = 15'b0000_1000_00_00_110;
  localparam logic [14:0] C_RTEX_AN = 15'b0000_1000_00_00_000;
  localparam logic [14:0] C_RTEX_OR = 15'b0000_1000_00_00_001;
  localparam logic [14:0] C_RTEX_SL = 15'b0000_1000_00_00_111;
  localparam logic [14:0] C_RTWB    = 15'b0010_0001_00_00_010;
  localparam logic [14:0] C_BEQ_T   = 15'b1000_1000_00_01_110;
  localparam logic [14:0] C_BEQ_N   = 15'b0000_1000_00_01_110;
  localparam logic [14:0] C_ADDIWB  = 15'b0010_0000_00_00_010;
  localparam logic [14:0] C_JEX     = 15'b1000_0000_00_10_010;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [14:0] ctl;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  // Clock
  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  function automatic void add(input logic r, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic [3:0] s, input logic [14:0] c,
                              input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.st = s; v.ctl = c; v.name = n;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs at the falling edge, then compare settled outputs
  task automatic run_cycle(input vec_t v);
    logic [14:0] act;
    @(negedge clk);
    reset = v.rst; op = v.op; funct = v.funct; zero = v.zero;
    #1;
    act = {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol};
    checks++;
    if (state !== v.st) begin
      failures++;
      $display("FAIL %s state: got %0d expected %0d", v.name, state, v.st);
    end
    checks++;
    if (act !== v.ctl) begin
      failures++;
      $display("FAIL %s ctl: got %b expected %b", v.name, act, v.ctl);
    end
  endtask

  initial begin
    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);

    // Table: one record per cycle, state is the value latched at the prior edge
    add(1, LW, 0, 0, 0, C_RESET,  "rst_hold");
    add(0, LW, 0, 1, 0, C_FETCH,  "lw_fetch");
    add(0, LW, 0, 1, 1, C_DECODE, "lw_decode");
    add(0, LW, 0, 1, 2, C_MEMADR, "lw_memadr");
    add(0, LW, 0, 1, 3, C_MEMRD,  "lw_memrd");
    add(0, LW, 0, 1, 4, C_MEMWB,  "lw_memwb");
    // SW interrupted by two reset cycles while in MEMWR
    add(0, SW, 0, 0, 0, C_FETCH,  "sw0_fetch");
    add(0, SW, 0, 0, 1, C_DECODE, "sw0_decode");
    add(0, SW, 0, 0, 2, C_MEMADR, "sw0_memadr");
    add(1, SW, 0, 0, 5, C_RESET,  "rst_in_memwr");
    add(1, SW, 0, 0, 0, C_RESET,  "rst_second");
    add(0, SW, 0, 0, 0, C_FETCH,  "rel_fetch");
    add(0, SW, 0, 0, 1, C_DECODE, "sw_decode");
    add(0, SW, 0, 0, 2, C_MEMADR, "sw_memadr");
    add(0, SW, 0, 0, 5, C_MEMWR,  "sw_memwr");
    // R-type, one per funct, plus an unknown funct
    add(0, RT, 6'b100000, 0, 0, C_FETCH,   "add_fetch");
    add(0, RT, 6'b100000, 0, 1, C_DECODE,  "add_decode");
    add(0, RT, 6'b100000, 0, 6, C_RTEX_AD, "add_ex");
    add(0, RT, 6'b100000, 0, 7, C_RTWB,    "add_wb");
    add(0, RT, 6'b100010, 0, 0, C_FETCH,   "sub_fetch");
    add(0, RT, 6'b100010, 0, 1, C_DECODE,  "sub_decode");
    add(0, RT, 6'b100010, 0, 6, C_RTEX_SB, "sub_ex");
    add(0, RT, 6'b100010, 0, 7, C_RTWB,    "sub_wb");
    add(0, RT, 6'b100100, 0, 0, C_FETCH,   "and_fetch");
    add(0, RT, 6'b100100, 0, 1, C_DECODE,  "and_decode");
    add(0, RT, 6'b100100, 0, 6, C_RTEX_AN, "and_ex");
    add(0, RT, 6'b100100, 0, 7, C_RTWB,    "and_wb");
    add(0, RT, 6'b100101, 0, 0, C_FETCH,   "or_fetch");
    add(0, RT, 6'b100101, 0, 1, C_DECODE,  "or_decode");
    add(0, RT, 6'b100101, 0, 6, C_RTEX_OR, "or_ex");
    add(0, RT, 6'b100101, 0, 7, C_RTWB,    "or_wb");
    add(0, RT, 6'b101010, 0, 0, C_FETCH,   "slt_fetch");
    add(0, RT, 6'b101010, 0, 1, C_DECODE,  "slt_decode");
    add(0, RT, 6'b101010, 0, 6, C_RTEX_SL, "slt_ex");
    add(0, RT, 6'b101010, 0, 7, C_RTWB,    "slt_wb");
    add(0, RT, 6'b000111, 0, 0, C_FETCH,   "unkf_fetch");
    add(0, RT, 6'b000111, 0, 1, C_DECODE,  "unkf_decode");
    add(0, RT, 6'b000111, 0, 6, C_RTEX_AD, "unkf_ex");
    add(0, RT, 6'b000111, 0, 7, C_RTWB,    "unkf_wb");
    // BEQ taken and not taken
    add(0, BEQ, 0, 1, 0, C_FETCH,  "beqt_fetch");
    add(0, BEQ, 0, 1, 1, C_DECODE, "beqt_decode");
    add(0, BEQ, 0, 1, 8, C_BEQ_T,  "beqt_ex");
    add(0, BEQ, 0, 0, 0, C_FETCH,  "beqn_fetch");
    add(0, BEQ, 0, 0, 1, C_DECODE, "beqn_decode");
    add(0, BEQ, 0, 0, 8, C_BEQ_N,  "beqn_ex");
    // J and ADDI with zero held high to show pcen ignores it outside BEQEX
    add(0, J, 0, 1, 0,  C_FETCH,  "j_fetch");
    add(0, J, 0, 1, 1,  C_DECODE, "j_decode");
    add(0, J, 0, 1, 11, C_JEX,    "j_ex");
    add(0, ADDI, 0, 1, 0,  C_FETCH,  "addi_fetch");
    add(0, ADDI, 0, 1, 1,  C_DECODE, "addi_decode");
    add(0, ADDI, 0, 1, 9,  C_MEMADR, "addi_ex");
    add(0, ADDI, 0, 1, 10, C_ADDIWB, "addi_wb");
    // Unsupported opcode: FETCH, DECODE, back to FETCH
    add(0, BAD, 0, 0, 0, C_FETCH,  "bad_fetch");
    add(0, BAD, 0, 0, 1, C_DECODE, "bad_decode");
    add(0, BAD, 0, 0, 0, C_FETCH,  "bad_refetch");

    foreach (vecs[i]) run_cycle(vecs[i]);

    // Hand sequence: reset while in BEQEX with zero=1 must suppress pcen
    // and restore FETCH-valued muxes immediately
    begin
      vec_t v;
      v = '{rst:0, op:BEQ, funct:0, zero:1, st:1, ctl:C_DECODE, name:"hs_decode"};
      run_cycle(v);
      v = '{rst:1, op:BEQ, funct:0, zero:1, st:8, ctl:C_RESET, name:"hs_rst_beqex"};
      run_cycle(v);
      v = '{rst:1, op:BEQ, funct:0, zero:1, st:0, ctl:C_RESET, name:"hs_rst_hold"};
      run_cycle(v);
      v = '{rst:0, op:RT, funct:6'b100010, zero:1, st:0, ctl:C_FETCH, name:"hs_release"};
      run_cycle(v);
      v = '{rst:0, op:RT, funct:6'b100010, zero:1, st:1, ctl:C_DECODE, name:"hs_rt_decode"};
      run_cycle(v);
      // reset during RTYPEEX: alucontrol must fall back to add
      v = '{rst:1, op:RT, funct:6'b100010, zero:1, st:6, ctl:C_RESET, name:"hs_rst_rtex"};
      run_cycle(v);
      v = '{rst:0, op:RT, funct:6'b100010, zero:1, st:0, ctl:C_FETCH, name:"hs_final_fetch"};
      run_cycle(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multi-cycle MIPS core: a Moore state machine plus an ALU-function decoder that drives every control input of the datapath and the write enable of the unified instruction/data memory. It consumes the datapath's `op`, `funct` and `zero` outputs and produces `pcen`, `irwrite`, `regwrite`, `alusrca`, `iord`, `memtoreg`, `regdst`, `alusrcb`, `pcsrc`, `alucontrol` and `memwrite`. It executes one instruction at a time, taking 3 to 5 cycles per instruction.

## Interface
- No parameters; all widths are fixed by the MIPS ISA.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — synchronous, active-high.
- `op` input 6 — `instr[31:26]` from the datapath.
- `funct` input 6 — `instr[5:0]` from the datapath.
- `zero` input 1 — ALU zero flag from the datapath, valid in the same cycle.
- `pcen` output 1 — PC register enable.
- `irwrite` output 1 — instruction register enable.
- `regwrite` output 1 — register file write enable.
- `memwrite` output 1 — memory write enable.
- `alusrca` output 1 — ALU A select: 0 = PC, 1 = register A.
- `iord` output 1 — memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg` output 1 — register write-data select: 0 = ALUOut, 1 = Data.
- `regdst` output 1 — destination register select: 0 = rt, 1 = rd.
- `alusrcb` output 2 — ALU B select: 00 = B, 01 = constant 4, 10 = signimm, 11 = signimm shifted left by 2.
- `pcsrc` output 2 — next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` output 3 — ALU operation.
- `state` output 4 — current state encoding, for debug and the bench.

## Operation
- Opcodes:
  - RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
  - Any other opcode is unsupported.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
  - Codes 12–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE goes by `op`: LW or SW → MEMADR, RTYPE → RTYPEEX, BEQ → BEQEX, ADDI → ADDIEX, J → JEX, unsupported → FETCH (executes as a no-op).
  - MEMADR → MEMRD for LW, MEMWR for SW.
  - MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX all → FETCH.
- Outputs are a function of state only, except `alucontrol` and `pcen`. Any output not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Internal signals: `pcwrite`, `branch` and the 2-bit `aluop`.
- pcen = pcwrite | (branch & zero).
- ALU decode:
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (subtract).
  - aluop 10 decodes `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other funct → 010.
  - aluop 11 → 010.
- While `reset` is high:
  - `pcen`, `irwrite`, `regwrite` and `memwrite` are forced to 0.
  - All other outputs follow the FETCH values.

## Timing
- State register updates on the rising edge of `clk`. Synchronous reset loads FETCH.
- After reset deasserts, the first cycle is FETCH.
- Reset asserted mid-instruction: the next edge returns to FETCH, and no write enable is asserted in that cycle or any following reset cycle.
- Cycles per instruction:
  - LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
  - Unsupported opcode 2: FETCH then DECODE, with no architectural writes.
- `op` and `funct` are sampled combinationally in DECODE, MEMADR and RTYPEEX. The IR holds them stable because `irwrite` is 1 only in FETCH.
- `zero` is used combinationally in BEQEX only. There is no registered path from `zero` to `pcen`.
- No output depends on the inputs except `alucontrol` (on `funct`) and `pcen` (on `zero`).

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - the 4-bit state enum;
  - the ALU control codes.
- Sub-module `alu_decoder`: combinational, `aluop` + `funct` → `alucontrol`.
- The top module contains the state register, the next-state logic and the output decode.

## Test plan
- Reset for 2 cycles in the middle of an instruction, then release:
  - during reset, `pcen`, `irwrite`, `regwrite` and `memwrite` are 0;
  - the first cycle after release has state=0, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 (LW) → state sequence 0,1,2,3,4:
  - MEMRD has iord=1;
  - MEMWB has memtoreg=1, regwrite=1, regdst=0.
- op=101011 (SW) → states 0,1,2,5; memwrite=1 and iord=1 in the last cycle only.
- op=000000 with funct 100000, 100010, 100100, 100101, 101010 in turn → RTYPEEX has alucontrol 010, 110, 000, 001, 111 respectively, and RTYPEWB has regdst=1, regwrite=1.
- op=000100 (BEQ):
  - with zero=1: BEQEX has pcen=1, pcsrc=01, alucontrol=110;
  - with zero=0: pcen=0; state returns to 0 in both cases.
- Remaining instructions:
  - op=000010 (J) → JEX has pcen=1, pcsrc=10;
  - op=001000 (ADDI) → states 0,1,9,10, and ADDIWB has regwrite=1, regdst=0;
  - op=111111 → state 0,1,0 with no write enable asserted in DECODE.
